// File: rtl/dds_chirp_gen.sv
// dds_chirp_gen: linear-FM chirp phase generator with frequency/phase accumulators.
// Define CHIRP_DITHER_EN to add LFSR dither below the phase_out truncation point.
module dds_chirp_gen #(
    parameter int ACC_W   = 48,
    parameter int PHASE_W = 16,
    parameter int RATE_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [ACC_W-1:0]   freq_start,
    input  logic [ACC_W-1:0]   freq_step,
    input  logic [RATE_W-1:0]  step_rate,
    input  logic [CNT_W-1:0]   step_count,
    output logic [PHASE_W-1:0] phase_out,
    output logic [ACC_W-1:0]   freq_out,
    output logic               valid,
    output logic               busy,
    output logic               sweep_done
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state;
    logic start_d, dir, launch, bound, sweep_end;
    logic [1:0] mode_s;
    logic [ACC_W-1:0] fstart_s, fstep_s, freq, phase_acc, phase_nx, freq_nx, dith_acc;
    logic [RATE_W-1:0] rate_s, rate_cnt;
    logic [CNT_W-1:0] count_s, step_idx;
    assign launch = start & ~start_d;
    always_comb begin
        phase_nx  = phase_acc + freq;
        bound     = state == RUN && rate_cnt == rate_s;
        sweep_end = bound && step_idx == count_s;
        freq_nx   = (!bound || mode_s == 2'd3 || (sweep_end && mode_s != 2'd1)) ? freq :
                    sweep_end ? fstart_s :
                    dir ? freq - fstep_s : freq + fstep_s;
    end
`ifdef CHIRP_DITHER_EN
    localparam int DW = (ACC_W - PHASE_W > 16) ? 16 : ACC_W - PHASE_W;
    logic [15:0] lfsr;
    // Only bits below the output slice are dithered; the accumulator stays clean.
    assign dith_acc = phase_nx + ACC_W'(lfsr & (16'hFFFF >> (16 - DW)));
    always_ff @(posedge clk) begin
        if (rst || launch)
            lfsr <= 16'hACE1;
        else if (valid)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`else
    assign dith_acc = phase_nx;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start_d    <= 1'b1;
            dir        <= 1'b0;
            mode_s     <= '0;
            fstart_s   <= '0;
            fstep_s    <= '0;
            rate_s     <= '0;
            count_s    <= '0;
            freq       <= '0;
            phase_acc  <= '0;
            rate_cnt   <= '0;
            step_idx   <= '0;
            phase_out  <= '0;
            freq_out   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            start_d    <= start;
            sweep_done <= 1'b0;
            if (!start) begin
                state     <= IDLE;
                dir       <= 1'b0;
                phase_out <= '0;
                freq_out  <= '0;
                valid     <= 1'b0;
                busy      <= 1'b0;
            end else if (launch) begin
                mode_s    <= mode;
                fstart_s  <= freq_start;
                fstep_s   <= freq_step;
                rate_s    <= step_rate;
                count_s   <= step_count;
                freq      <= freq_start;
                phase_acc <= '0;
                rate_cnt  <= '0;
                step_idx  <= '0;
                dir       <= 1'b0;
                state     <= RUN;
                phase_out <= '0;
                freq_out  <= freq_start;
                valid     <= 1'b1;
                busy      <= 1'b1;
            end else if (state != IDLE) begin
                phase_acc <= phase_nx;
                phase_out <= dith_acc[ACC_W-1 -: PHASE_W];
                freq      <= freq_nx;
                freq_out  <= freq_nx;
                if (state == RUN) begin
                    rate_cnt <= bound ? '0 : rate_cnt + RATE_W'(1);
                    if (bound)
                        step_idx <= sweep_end ? '0 : step_idx + CNT_W'(1);
                    if (sweep_end) begin
                        sweep_done <= 1'b1;
                        if (mode_s == 2'd0)
                            state <= HOLD;
                        if (mode_s == 2'd2)
                            dir <= ~dir;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dds_chirp_gen.sv
// tb_dds_chirp_gen: scoreboard and table checks for dds_chirp_gen (ACC_W=PHASE_W=16).
module tb_dds_chirp_gen;
    localparam int AW = 16, PW = 16, RW = 32, CW = 16;
    logic clk = 0, rst = 1, start = 1;
    logic [1:0] mode = 0;
    logic [AW-1:0] freq_start = 0, freq_step = 0;
    logic [RW-1:0] step_rate = 0;
    logic [CW-1:0] step_count = 0;
    logic [PW-1:0] phase_out;
    logic [AW-1:0] freq_out;
    logic valid, busy, sweep_done;
    int total = 0, bad = 0;

    typedef struct {
        logic [1:0] mode;
        logic [AW-1:0] fs, fst;
        logic [RW-1:0] rate;
        logic [CW-1:0] cnt;
        int ncyc;
    } vec_t;
    typedef struct {
        logic [PW-1:0] ph;
        logic [AW-1:0] fr;
        logic v, b, d;
    } exp_t;
    exp_t sbq[$];
    vec_t vecs[7];
    int f1[16] = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130, 130, 130, 130, 130};
    int p1[6] = '{0, 100, 200, 300, 410, 520};
    int f3[10] = '{1000, 984, 968, 968, 984, 1000, 1000, 984, 968, 968};

    always #5 clk = ~clk;

    dds_chirp_gen #(.ACC_W(AW), .PHASE_W(PW), .RATE_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .freq_start(freq_start),
        .freq_step(freq_step), .step_rate(step_rate), .step_count(step_count),
        .phase_out(phase_out), .freq_out(freq_out), .valid(valid), .busy(busy),
        .sweep_done(sweep_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        start = 0;
        @(negedge clk);
        mode = v.mode; freq_start = v.fs; freq_step = v.fst;
        step_rate = v.rate; step_count = v.cnt;
        start = 1;
    endtask

    task automatic run_model(input vec_t v);
        logic [AW-1:0] acc, fr;
        logic [RW-1:0] rc;
        logic [CW-1:0] idx;
        logic dir, hold, d;
        exp_t e;
        acc = 0; fr = v.fs; rc = 0; idx = 0; dir = 0; hold = 0;
        launch(v);
        sbq.push_back('{0, v.fs, 1'b1, 1'b1, 1'b0});
        for (int k = 0; k < v.ncyc; k++) begin
            @(negedge clk);
            e = sbq.pop_front();
            chk("phase", phase_out, e.ph);
            chk("freq", freq_out, e.fr);
            chk("valid", valid, e.v);
            chk("busy", busy, e.b);
            chk("done", sweep_done, e.d);
            // Inputs must be ignored mid-sweep
            freq_start = AW'($urandom); freq_step = AW'($urandom); mode = 2'($urandom);
            step_rate = RW'($urandom_range(5)); step_count = CW'($urandom_range(5));
            acc = acc + fr; d = 0;
            if (!hold) begin
                if (rc == v.rate) begin
                    rc = 0;
                    if (idx == v.cnt) begin
                        d = 1; idx = 0;
                        if (v.mode == 0) hold = 1;
                        if (v.mode == 1) fr = v.fs;
                        if (v.mode == 2) dir = ~dir;
                    end else begin
                        idx++;
                        if (v.mode != 3) fr = dir ? fr - v.fst : fr + v.fst;
                    end
                end else rc++;
            end
            sbq.push_back('{acc, fr, 1'b1, 1'b1, d});
        end
        sbq.delete();
    endtask

`ifdef CHIRP_DITHER_EN
    logic [15:0] d_ph;
    logic [23:0] d_fr, d_fs = 0;
    logic d_v, d_b, d_d, d_start = 0;
    dds_chirp_gen #(.ACC_W(24), .PHASE_W(16), .RATE_W(8), .CNT_W(4)) u_dith (
        .clk(clk), .rst(rst), .start(d_start), .mode(2'd3), .freq_start(d_fs),
        .freq_step(24'd0), .step_rate(8'd0), .step_count(4'd0),
        .phase_out(d_ph), .freq_out(d_fr), .valid(d_v), .busy(d_b), .sweep_done(d_d)
    );
    task automatic dither_test(input logic [23:0] fs);
        logic [23:0] acc, tmp;
        logic [15:0] l, ph;
        acc = 0; l = 16'hACE1; ph = 0;
        @(negedge clk); d_start = 0;
        @(negedge clk); d_fs = fs; d_start = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("dither_phase", d_ph, ph);
            acc = acc + fs;
            tmp = acc + {16'd0, l[7:0]};
            ph = tmp[23:8];
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        d_start = 0;
    endtask
`endif

    initial begin
        vecs[0] = '{2'd1, 16'd100, 16'd10, 32'd2, 16'd3, 40};
        vecs[1] = '{2'd2, 16'd1000, 16'hFFF0, 32'd0, 16'd2, 30};
        vecs[2] = '{2'd0, 16'hFFF0, 16'd32, 32'd0, 16'd1, 12};
        vecs[3] = '{2'd3, 16'd500, 16'd7, 32'd1, 16'd2, 24};
        vecs[4] = '{2'd1, 16'h1234, 16'h0F00, 32'd3, 16'd0, 25};
        vecs[5] = '{2'd2, 16'd40000, 16'd300, 32'd1, 16'd4, 40};
        vecs[6] = '{2'd0, 16'hF000, 16'h0800, 32'd0, 16'd5, 14};
        // Reset with start held high: outputs zero and no launch afterwards
        repeat (3) @(negedge clk);
        chk("rst_phase", phase_out, 0);
        chk("rst_freq", freq_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", sweep_done, 0);
        freq_start = 16'd77;
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_launch_busy", busy, 0);
            chk("no_launch_valid", valid, 0);
        end
        // Mode 0 single sweep, constants from hand derivation
        launch(vecs[0]);
        mode = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("m0_freq", freq_out, f1[k]);
            chk("m0_done", sweep_done, k == 12);
            chk("m0_busy", busy, 1);
            if (k < 6) chk("m0_phase", phase_out, p1[k]);
        end
        // Mode 2 triangle with negative step
        launch(vecs[1]);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("m2_freq", freq_out, f3[k]);
            chk("m2_done", sweep_done, k > 0 && k % 3 == 0);
        end
        for (int i = 0; i < 7; i++) run_model(vecs[i]);
        // Abort mid-run for one cycle, then relaunch
        launch(vecs[3]);
        repeat (5) @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_phase", phase_out, 0);
        chk("abort_freq", freq_out, 0);
        freq_start = 16'd321;
        start = 1;
        @(negedge clk);
        chk("relaunch_phase", phase_out, 0);
        chk("relaunch_freq", freq_out, 321);
        chk("relaunch_valid", valid, 1);
        @(negedge clk);
        chk("relaunch_phase2", phase_out, 321);
        // Reset during a run with start held high
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_run_busy", busy, 0);
            chk("rst_run_freq", freq_out, 0);
        end
`ifdef CHIRP_DITHER_EN
        dither_test(24'd0);
        dither_test(24'd255);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
